// File: rtl/register_writeback.sv
// -----------------------------------------------------------------------------
// register_writeback
//
// Merges two register-file write sources into one registered write port:
//   * the in-order pipeline writeback, which has priority, and
//   * long-latency (load/divide) results, buffered in a small FIFO and drained
//     in any cycle the pipeline does not write.
// A starvation counter stalls the pipeline port after STARVE_MAX consecutive
// cycles in which the FIFO was blocked, so queued results always make progress.
// Decode read ports are checked against every write still in flight (FIFO
// entries plus the output register) to flag read-after-write hazards.
//
// Parameters
//   DEPTH       long-latency FIFO entries (power of two, 2..16)
//   STARVE_MAX  blocked-drain cycles before pipe_stall is raised
//
// Configuration macro
//   WB_BYPASS_EN  when defined, a result arriving while the FIFO is empty and
//                 the output register is otherwise unused is written straight
//                 to the output register (one-cycle latency).
//
// Ports
//   clk                               clock, all state on rising edge
//   rst                               asynchronous reset, active-low
//   pipe_wren/pipe_waddr/pipe_wdata   pipeline writeback request
//   pipe_stall                        pipeline request not accepted this cycle
//   lsu_valid/lsu_waddr/lsu_wdata     long-latency result
//   lsu_ready                         FIFO accepts a result this cycle
//   rden1/raddr1, rden2/raddr2        decode read requests
//   hazard1/hazard2                   read address has a write in flight
//   wren/waddr/wdata                  registered register-file write
// -----------------------------------------------------------------------------
module register_writeback #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wren,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_waddr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_ready,
    input  logic        rden1,
    input  logic [4:0]  raddr1,
    input  logic        rden2,
    input  logic [4:0]  raddr2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        wren,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STV_W  = $clog2(STARVE_MAX + 1);

    // Starvation count never needs to exceed STARVE_MAX.
    function automatic logic [STV_W-1:0] starve_inc(input logic [STV_W-1:0] v);
        if (v == STV_W'(STARVE_MAX)) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;

    logic              fifo_empty;
    logic              pipe_acc;
    logic              lsu_acc;
    logic              enq;
    logic              deq;
    logic              bypass;
    logic              push;

    logic [PTR_W-1:0]  offset;
    logic              in_fifo1;
    logic              in_fifo2;

    assign fifo_empty = (count == '0);
    assign pipe_stall = (starve == STV_W'(STARVE_MAX));
    assign pipe_acc   = pipe_wren && !pipe_stall;
    // The pipeline owns the output register whenever it writes; the FIFO
    // drains in every other cycle, which includes every stalled cycle.
    assign deq        = !fifo_empty && !pipe_acc;

    // Ready comes from the registered count only; a same-cycle dequeue does
    // not make room. Held low while reset is asserted.
    assign lsu_ready  = rst && (count < CNT_W'(DEPTH));
    assign lsu_acc    = lsu_valid && lsu_ready;
    // Results for x0 are accepted but never stored.
    assign enq        = lsu_acc && (lsu_waddr != '0);

`ifdef WB_BYPASS_EN
    assign bypass     = enq && fifo_empty && !pipe_acc && !deq;
`else
    assign bypass     = 1'b0;
`endif

    assign push       = enq && !bypass;

    // Accept stage -> FIFO storage (data path, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_waddr;
            fifo_data[wr_ptr] <= lsu_wdata;
        end
    end

    // Accept stage -> FIFO control, starvation counter, output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
            wren   <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(deq);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (fifo_empty || deq) begin
                starve <= '0;
            end else if (pipe_acc) begin
                starve <= starve_inc(starve);
            end

            if (pipe_acc) begin
                wren  <= (pipe_waddr != '0);
                waddr <= pipe_waddr;
                wdata <= pipe_wdata;
            end else if (deq) begin
                wren  <= 1'b1;
                waddr <= fifo_addr[rd_ptr];
                wdata <= fifo_data[rd_ptr];
            end else if (bypass) begin
                wren  <= 1'b1;
                waddr <= lsu_waddr;
                wdata <= lsu_wdata;
            end else begin
                wren  <= 1'b0;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the
    // occupancy; the pointer subtraction wraps modulo DEPTH.
    always_comb begin
        offset   = '0;
        in_fifo1 = 1'b0;
        in_fifo2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ({1'b0, offset} < count) begin
                if (fifo_addr[i] == raddr1) in_fifo1 = 1'b1;
                if (fifo_addr[i] == raddr2) in_fifo2 = 1'b1;
            end
        end
    end

    assign hazard1 = rden1 && (raddr1 != '0) &&
                     (in_fifo1 || (wren && (waddr == raddr1)));
    assign hazard2 = rden2 && (raddr2 != '0) &&
                     (in_fifo2 || (wren && (waddr == raddr2)));

endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wren;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        rden1;
    logic [4:0]  raddr1;
    logic        rden2;
    logic [4:0]  raddr2;
    logic        hazard1;
    logic        hazard2;
    logic        wren;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

`ifdef WB_BYPASS_EN
    localparam int WCYC = 0;  // cycle (after acceptance edge) whose edge writes the first result
`else
    localparam int WCYC = 1;
`endif

    register_writeback #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_wren(pipe_wren), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .lsu_ready(lsu_ready),
        .rden1(rden1), .raddr1(raddr1), .rden2(rden2), .raddr2(raddr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .wren(wren), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        r1;
        logic [4:0]  a1;
        logic        r2;
        logic [4:0]  a2;
        logic        e_stall;
        logic        e_ready;
        logic        e_h1;
        logic        e_h2;
        logic        e_wren;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        pipe_wren = pw; pipe_waddr = pa; pipe_wdata = pd;
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        rden1 = r1; raddr1 = a1; rden2 = r2; raddr2 = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic chk_write(input string name, input logic ew, input logic [4:0] ea,
                             input logic [31:0] ed);
        chk({name, ".wren"}, 32'(wren), 32'(ew));
        if (ew) begin
            chk({name, ".waddr"}, 32'(waddr), 32'(ea));
            chk({name, ".wdata"}, wdata, ed);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            pw pa  pd            lv la ld            r1 a1 r2 a2  st rd h1 h2  wr wa wd
        vecs[0] = '{1'b1, 5'd5, 32'hAAAA0001, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hAAAA0001};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[3] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b1, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[6] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,   1'b0, 5'd0, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b1, 5'd3,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b0, 5'd9,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

        // Reset values while reset is held, then release
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst.wren", 32'(wren), 32'd0);
        chk("rst.waddr", 32'(waddr), 32'd0);
        chk("rst.wdata", wdata, 32'd0);
        chk("rst.lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst.pipe_stall", 32'(pipe_stall), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rel.lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rel.pipe_stall", 32'(pipe_stall), 32'd0);

        // Table-driven vectors, applied back to back
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld,
                  vecs[i].r1, vecs[i].a1, vecs[i].r2, vecs[i].a2);
            #1;
            chk($sformatf("vec%0d.pipe_stall", i), 32'(pipe_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d.lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d.hazard1", i), 32'(hazard1), 32'(vecs[i].e_h1));
            chk($sformatf("vec%0d.hazard2", i), 32'(hazard2), 32'(vecs[i].e_h2));
            tick();
            chk_write($sformatf("vec%0d", i), vecs[i].e_wren, vecs[i].e_waddr, vecs[i].e_wdata);
        end

        // Ordered drain of three results with the pipeline idle
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            int idx;
            if (i < 3) drive(0, 0, 0, 1, 5'(i + 1), 32'(17 * (i + 1)), 0, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("drain%0d.lsu_ready", i), 32'(lsu_ready), 32'd1);
            tick();
            idx = i - WCYC;
            if (idx >= 0 && idx < 3)
                chk_write($sformatf("drain%0d", i), 1'b1, 5'(idx + 1), 32'(17 * (idx + 1)));
            else
                chk_write($sformatf("drain%0d", i), 1'b0, 5'd0, 32'd0);
        end

        // Full FIFO under continuous pipeline writes, starvation stall
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            logic [31:0] pd;
            logic        e_ready;
            pd = (i <= 9) ? 32'(i) : 32'd9;
            if (i < 4) drive(1, 5'd10, pd, 1, 5'(20 + i), 32'(256 + i), 0, 0, 0, 0);
            else       drive(1, 5'd10, pd, 0, 0, 0, 0, 0, 0, 0);
            #1;
            e_ready = (i < 4) || (i > 9);
            chk($sformatf("full%0d.pipe_stall", i), 32'(pipe_stall), 32'(i == 9));
            chk($sformatf("full%0d.lsu_ready", i), 32'(lsu_ready), 32'(e_ready));
            tick();
            if (i == 9) chk_write($sformatf("full%0d", i), 1'b1, 5'd20, 32'h100);
            else        chk_write($sformatf("full%0d", i), 1'b1, 5'd10, pd);
        end

        // Hazard tracking of a queued result to x7; raddr 0 never flags
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(0, 0, 0, 1, 5'd7, 32'h77, 1, 5'd7, 1, 5'd0);
            else        drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 1, 5'd0);
            #1;
            chk($sformatf("haz%0d.hazard1", i), 32'(hazard1), 32'(i >= 1 && i <= WCYC + 1));
            chk($sformatf("haz%0d.hazard2", i), 32'(hazard2), 32'd0);
            tick();
            if (i == WCYC) chk_write($sformatf("haz%0d", i), 1'b1, 5'd7, 32'h77);
            else           chk_write($sformatf("haz%0d", i), 1'b0, 5'd0, 32'd0);
        end

        // Mid-operation reset with three results queued
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd10, 32'(i), 1, 5'(i + 1), 32'(i), 0, 0, 0, 0);
            tick();
            chk_write($sformatf("mrst%0d", i), 1'b1, 5'd10, 32'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mrst.wren", 32'(wren), 32'd0);
        chk("mrst.waddr", 32'(waddr), 32'd0);
        chk("mrst.wdata", wdata, 32'd0);
        chk("mrst.lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 5'd1, 1, 5'd3);
            #1;
            chk($sformatf("post%0d.lsu_ready", i), 32'(lsu_ready), 32'd1);
            chk($sformatf("post%0d.hazard1", i), 32'(hazard1), 32'd0);
            chk($sformatf("post%0d.hazard2", i), 32'(hazard2), 32'd0);
            tick();
            chk_write($sformatf("post%0d", i), 1'b0, 5'd0, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
